// File: rtl/t2mi_from_ts_if.sv
// Byte-stream bundle between a TS source and the T2-MI depacketiser.
// Master drives the TS side, slave (the depacketiser) drives the T2-MI side.
interface t2mi_from_ts_if;
    logic [7:0] DATA_IN;
    logic       ENA_IN;
    logic       PSYNC_IN;
    logic [7:0] DATA_OUT;
    logic       ENA_OUT;
    logic       START_OUT;

    modport master (output DATA_IN, ENA_IN, PSYNC_IN, input  DATA_OUT, ENA_OUT, START_OUT);
    modport slave  (input  DATA_IN, ENA_IN, PSYNC_IN, output DATA_OUT, ENA_OUT, START_OUT);
endinterface

// File: rtl/t2mi_from_ts.sv
// Extracts the T2-MI byte stream from TS packets on t2mi_pid: strips header,
// adaptation field and pointer_field, flags the first byte of every T2-MI packet.
module t2mi_from_ts #(
    parameter int TS_LEN   = 188,
    parameter bit CHECK_CC = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    t2mi_from_ts_if.slave ts,
    input  logic [12:0]   t2mi_pid,
    output logic          LOCKED,
    output logic          CC_ERR,
    output logic          SYNC_ERR,
    output logic [3:0]    state_mon
);
    typedef enum logic [3:0] {
        WAIT_SYNC = 4'd0, HEADER = 4'd1, AF_LEN = 4'd2, AF_SKIP = 4'd3,
        POINTER   = 4'd4, PAYLOAD = 4'd5, DISCARD = 4'd6
    } state_t;

    localparam logic [7:0] LAST = 8'(TS_LEN - 1);

    state_t      state_q, state_d, after_af;
    logic [7:0]  idx_q, idx_d, cnt_q, cnt_d, dout_q, dout_d, af_lim;
    logic [4:0]  pid_hi_q, pid_hi_d;
    logic [1:0]  afc_q, afc_d;
    logic [3:0]  cc_last_q, cc_last_d, cc_exp;
    logic        tei_q, tei_d, pusi_q, pusi_d, pid_ok_q, pid_ok_d;
    logic        cc_vld_q, cc_vld_d, locked_q, locked_d, ptr_act_q, ptr_act_d;
    logic        sync_exp_q, sync_exp_d;
    logic        ena_q, ena_d, start_q, start_d, cc_err_q, cc_err_d, serr_q, serr_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= WAIT_SYNC;
            idx_q      <= '0;
            cnt_q      <= '0;
            dout_q     <= '0;
            pid_hi_q   <= '0;
            afc_q      <= '0;
            cc_last_q  <= '0;
            tei_q      <= 1'b0;
            pusi_q     <= 1'b0;
            pid_ok_q   <= 1'b0;
            cc_vld_q   <= 1'b0;
            locked_q   <= 1'b0;
            ptr_act_q  <= 1'b0;
            sync_exp_q <= 1'b0;
            ena_q      <= 1'b0;
            start_q    <= 1'b0;
            cc_err_q   <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            pid_hi_q   <= pid_hi_d;
            afc_q      <= afc_d;
            cc_last_q  <= cc_last_d;
            tei_q      <= tei_d;
            pusi_q     <= pusi_d;
            pid_ok_q   <= pid_ok_d;
            cc_vld_q   <= cc_vld_d;
            locked_q   <= locked_d;
            ptr_act_q  <= ptr_act_d;
            sync_exp_q <= sync_exp_d;
            ena_q      <= ena_d;
            start_q    <= start_d;
            cc_err_q   <= cc_err_d;
            serr_q     <= serr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        pid_hi_d   = pid_hi_q;
        afc_d      = afc_q;
        cc_last_d  = cc_last_q;
        tei_d      = tei_q;
        pusi_d     = pusi_q;
        pid_ok_d   = pid_ok_q;
        cc_vld_d   = cc_vld_q;
        locked_d   = locked_q;
        ptr_act_d  = ptr_act_q;
        sync_exp_d = sync_exp_q;
        ena_d      = 1'b0;
        start_d    = 1'b0;
        cc_err_d   = 1'b0;
        serr_d     = 1'b0;
        cc_exp     = (afc_q == 2'b10) ? cc_last_q : cc_last_q + 4'd1;
        after_af   = (afc_q == 2'b10) ? DISCARD : (pusi_q ? POINTER : PAYLOAD);
        // AF must leave room for at least one payload byte when payload follows
        af_lim     = LAST - idx_q - {7'd0, afc_q[0]};

        if (ts.ENA_IN) begin
            idx_d = idx_q + 8'd1;
            if (state_q != WAIT_SYNC && ts.PSYNC_IN) begin
                serr_d   = 1'b1;
                locked_d = 1'b0;
                state_d  = HEADER;
                idx_d    = 8'd1;
            end else begin
                case (state_q)
                    WAIT_SYNC: begin
                        idx_d = '0;
                        if (ts.PSYNC_IN && ts.DATA_IN == 8'h47) begin
                            state_d    = HEADER;
                            idx_d      = 8'd1;
                            sync_exp_d = 1'b0;
                        end else if (sync_exp_q) begin
                            // missing sync right after a packet; fall back to hunting
                            serr_d     = 1'b1;
                            locked_d   = 1'b0;
                            sync_exp_d = 1'b0;
                        end
                    end
                    HEADER: begin
                        if (idx_q == 8'd1) begin
                            tei_d    = ts.DATA_IN[7];
                            pusi_d   = ts.DATA_IN[6];
                            pid_hi_d = ts.DATA_IN[4:0];
                        end else if (idx_q == 8'd2) begin
                            pid_ok_d = ({pid_hi_q, ts.DATA_IN} == t2mi_pid);
                        end else begin
                            afc_d = ts.DATA_IN[5:4];
                            cc_exp = (ts.DATA_IN[5:4] == 2'b10) ? cc_last_q : cc_last_q + 4'd1;
                            if (!pid_ok_q || tei_q || ts.DATA_IN[7:6] != 2'b00 ||
                                ts.DATA_IN[5:4] == 2'b00) begin
                                state_d = DISCARD;
                            end else begin
                                if (CHECK_CC && cc_vld_q && ts.DATA_IN[3:0] != cc_exp) begin
                                    cc_err_d = 1'b1;
                                    locked_d = 1'b0;
                                end
                                cc_last_d = ts.DATA_IN[3:0];
                                cc_vld_d  = 1'b1;
                                state_d   = ts.DATA_IN[5] ? AF_LEN : (pusi_q ? POINTER : PAYLOAD);
                            end
                        end
                    end
                    AF_LEN: begin
                        if (ts.DATA_IN > af_lim) begin
                            serr_d   = 1'b1;
                            locked_d = 1'b0;
                            state_d  = DISCARD;
                        end else if (ts.DATA_IN == 8'd0) begin
                            state_d = after_af;
                        end else begin
                            cnt_d   = ts.DATA_IN;
                            state_d = AF_SKIP;
                        end
                    end
                    AF_SKIP: begin
                        cnt_d = cnt_q - 8'd1;
                        if (cnt_q == 8'd1) state_d = after_af;
                    end
                    POINTER: begin
                        if (ts.DATA_IN >= LAST - idx_q) begin
                            serr_d   = 1'b1;
                            locked_d = 1'b0;
                            state_d  = DISCARD;
                        end else begin
                            cnt_d     = ts.DATA_IN;
                            ptr_act_d = 1'b1;
                            state_d   = PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        dout_d = ts.DATA_IN;
                        if (ptr_act_q && cnt_q == 8'd0) begin
                            ena_d     = 1'b1;
                            start_d   = 1'b1;
                            locked_d  = 1'b1;
                            ptr_act_d = 1'b0;
                        end else begin
                            ena_d = locked_q;
                            if (ptr_act_q) cnt_d = cnt_q - 8'd1;
                        end
                    end
                    default: ;
                endcase
                if (state_q != WAIT_SYNC && idx_q == LAST) begin
                    state_d    = WAIT_SYNC;
                    idx_d      = '0;
                    ptr_act_d  = 1'b0;
                    sync_exp_d = 1'b1;
                end
            end
        end
    end

    assign ts.DATA_OUT  = dout_q;
    assign ts.ENA_OUT   = ena_q;
    assign ts.START_OUT = start_q;
    assign LOCKED       = locked_q;
    assign CC_ERR       = cc_err_q;
    assign SYNC_ERR     = serr_q;
    assign state_mon    = state_q;
endmodule

// File: tb/tb_t2mi_from_ts.sv
// Scoreboard bench for t2mi_from_ts: packets are built byte by byte, expected
// T2-MI bytes are queued at build time and matched against ENA_OUT beats.
module tb_t2mi_from_ts;
    localparam int TS_LEN = 188;
    localparam logic [12:0] PID = 13'h1000;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [12:0] t2mi_pid = PID;
    logic        LOCKED, CC_ERR, SYNC_ERR;
    logic [3:0]  state_mon;

    t2mi_from_ts_if bus();

    t2mi_from_ts #(.TS_LEN(TS_LEN), .CHECK_CC(1'b1)) dut (
        .CLK(CLK), .RST(RST), .ts(bus), .t2mi_pid(t2mi_pid),
        .LOCKED(LOCKED), .CC_ERR(CC_ERR), .SYNC_ERR(SYNC_ERR), .state_mon(state_mon)
    );

    always #5 CLK = ~CLK;

    int n_tot = 0, n_pass = 0;
    int cc_errs = 0, sync_errs = 0;
    logic [8:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            if (CC_ERR) cc_errs++;
            if (SYNC_ERR) sync_errs++;
            if (bus.START_OUT && !bus.ENA_OUT) chk("start_wo_ena", 1, 0);
            if (bus.ENA_OUT) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    chk("data", {24'd0, bus.DATA_OUT}, {24'd0, e[7:0]});
                    chk("start", {31'd0, bus.START_OUT}, {31'd0, e[8]});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic put_byte(input logic [7:0] d, input logic ps);
        if ($urandom_range(0, 4) == 0) begin
            @(negedge CLK);
            bus.ENA_IN = 1'b0;
            bus.PSYNC_IN = 1'b0;
        end
        @(negedge CLK);
        bus.DATA_IN = d;
        bus.ENA_IN = 1'b1;
        bus.PSYNC_IN = ps;
    endtask

    task automatic settle(input string tag);
        @(negedge CLK);
        bus.ENA_IN = 1'b0;
        bus.PSYNC_IN = 1'b0;
        repeat (3) @(negedge CLK);
        chk(tag, sb.size(), 0);
    endtask

    // exp_from: first payload index expected out (999 = none); exp_start: payload index with START
    task automatic send_pkt(input logic [12:0] pid, input bit tei, input bit pusi,
                            input logic [1:0] afc, input logic [3:0] cc, input int af_len,
                            input int ptr, input int exp_from, input int exp_start,
                            input int trunc, input int seed);
        logic [7:0] pkt [TS_LEN];
        int p;
        for (int i = 0; i < TS_LEN; i++) pkt[i] = 8'hFF;
        pkt[0] = 8'h47;
        pkt[1] = {tei, pusi, 1'b0, pid[12:8]};
        pkt[2] = pid[7:0];
        pkt[3] = {2'b00, afc, cc};
        p = 4;
        if (afc[1]) begin
            pkt[p] = 8'(af_len);
            p = p + 1 + af_len;
        end
        if (afc[0] && pusi && p < TS_LEN) begin
            pkt[p] = 8'(ptr);
            p++;
        end
        if (afc[0]) begin
            for (int k = 0; p + k < TS_LEN; k++) begin
                pkt[p + k] = 8'(seed + k);
                if (k >= exp_from && p + k < trunc) sb.push_back({k == exp_start, 8'(seed + k)});
            end
        end
        for (int i = 0; i < trunc; i++) put_byte(pkt[i], i == 0);
    endtask

    int ce0, se0;

    initial begin
        bus.DATA_IN = '0;
        bus.ENA_IN = 1'b0;
        bus.PSYNC_IN = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_locked", LOCKED, 0);
        chk("rst_state", state_mon, 0);
        chk("rst_ena", bus.ENA_OUT, 0);
        chk("rst_errs", {CC_ERR, SYNC_ERR, bus.START_OUT}, 0);
        RST = 1'b1;

        // first PUSI packet, pointer 0: 183 bytes, START on byte 0
        send_pkt(PID, 0, 1, 2'b01, 4'd0, 0, 0, 0, 0, TS_LEN, 0);
        settle("t1_sb");
        chk("t1_locked", LOCKED, 1);

        // locked, pointer 10: tail bytes out, START on 11th
        send_pkt(PID, 0, 1, 2'b01, 4'd1, 0, 10, 0, 10, TS_LEN, 50);
        settle("t2_sb");
        chk("t2_locked", LOCKED, 1);

        // AF-stuffed forms, and AF-only packet repeating CC
        ce0 = cc_errs;
        send_pkt(PID, 0, 0, 2'b11, 4'd2, 0, 0, 0, 999, TS_LEN, 100);
        settle("t3a_sb");
        send_pkt(PID, 0, 0, 2'b10, 4'd2, 183, 0, 999, 999, TS_LEN, 0);
        settle("t3af_sb");
        send_pkt(PID, 0, 0, 2'b11, 4'd3, 5, 0, 0, 999, TS_LEN, 7);
        settle("t3b_sb");
        send_pkt(PID, 0, 0, 2'b01, 4'd4, 0, 0, 0, 999, TS_LEN, 9);
        settle("t4a_sb");
        chk("t3_no_ccerr", cc_errs - ce0, 0);

        // CC jump 4 -> 6
        send_pkt(PID, 0, 0, 2'b01, 4'd6, 0, 0, 999, 999, TS_LEN, 1);
        settle("t4b_sb");
        chk("t4_ccerr", cc_errs - ce0, 1);
        chk("t4_locked", LOCKED, 0);
        send_pkt(PID, 0, 0, 2'b01, 4'd7, 0, 0, 999, 999, TS_LEN, 2);
        settle("t4c_sb");
        send_pkt(PID, 0, 1, 2'b01, 4'd8, 0, 20, 20, 20, TS_LEN, 3);
        settle("t4d_sb");
        chk("t4_relock", LOCKED, 1);

        // foreign PID and TEI: dropped, CC history untouched
        ce0 = cc_errs;
        send_pkt(13'h0100, 0, 1, 2'b01, 4'd0, 0, 0, 999, 999, TS_LEN, 4);
        settle("t5a_sb");
        send_pkt(PID, 1, 1, 2'b01, 4'd0, 0, 0, 999, 999, TS_LEN, 5);
        settle("t5b_sb");
        send_pkt(PID, 0, 0, 2'b01, 4'd9, 0, 0, 0, 999, TS_LEN, 6);
        settle("t5c_sb");
        chk("t5_no_ccerr", cc_errs - ce0, 0);
        chk("t5_locked", LOCKED, 1);

        // early sync at idx 100, then oversized pointer and AF
        se0 = sync_errs;
        send_pkt(PID, 0, 0, 2'b01, 4'd10, 0, 0, 0, 999, 100, 11);
        send_pkt(PID, 0, 1, 2'b01, 4'd11, 0, 0, 0, 0, TS_LEN, 12);
        settle("t6a_sb");
        chk("t6_early_serr", sync_errs - se0, 1);
        chk("t6_locked", LOCKED, 1);
        send_pkt(PID, 0, 1, 2'b01, 4'd12, 0, 190, 999, 999, TS_LEN, 13);
        settle("t6b_sb");
        chk("t6_ptr_serr", sync_errs - se0, 2);
        chk("t6_ptr_locked", LOCKED, 0);
        send_pkt(PID, 0, 1, 2'b11, 4'd13, 183, 0, 999, 999, TS_LEN, 14);
        settle("t6c_sb");
        chk("t6_af_serr", sync_errs - se0, 3);

        // largest legal pointer, then CC wrap 15 -> 0
        ce0 = cc_errs;
        send_pkt(PID, 0, 1, 2'b01, 4'd14, 0, 182, 182, 182, TS_LEN, 15);
        settle("t7a_sb");
        chk("t7_locked", LOCKED, 1);
        send_pkt(PID, 0, 0, 2'b01, 4'd15, 0, 0, 0, 999, TS_LEN, 16);
        send_pkt(PID, 0, 0, 2'b01, 4'd0, 0, 0, 0, 999, TS_LEN, 17);
        settle("t7b_sb");
        chk("t7_wrap_ccerr", cc_errs - ce0, 0);

        // missing sync where one is expected
        se0 = sync_errs;
        put_byte(8'h00, 1'b0);
        settle("t8a_sb");
        chk("t8_serr", sync_errs - se0, 1);
        chk("t8_locked", LOCKED, 0);
        send_pkt(PID, 0, 0, 2'b01, 4'd1, 0, 0, 999, 999, TS_LEN, 18);
        send_pkt(PID, 0, 1, 2'b01, 4'd2, 0, 0, 0, 0, TS_LEN, 19);
        settle("t8b_sb");
        chk("t8_relock", LOCKED, 1);

        // async reset mid-packet, rest of packet must produce nothing
        send_pkt(PID, 0, 0, 2'b01, 4'd3, 0, 0, 0, 999, 50, 20);
        settle("t9a_sb");
        RST = 1'b0;
        #1;
        chk("t9_locked", LOCKED, 0);
        chk("t9_state", state_mon, 0);
        chk("t9_ena", bus.ENA_OUT, 0);
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 50; i < TS_LEN; i++) put_byte(8'(20 + i), 1'b0);
        settle("t9b_sb");
        ce0 = cc_errs;
        se0 = sync_errs;
        send_pkt(PID, 0, 1, 2'b01, 4'd9, 0, 0, 0, 0, TS_LEN, 21);
        settle("t9c_sb");
        chk("t9_errs", (cc_errs - ce0) + (sync_errs - se0), 0);
        chk("t9_relock", LOCKED, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
